// File: rtl/execute_cycle_if.sv
// Bundle of the ID/EX inputs, forwarding selects and EX/MEM outputs of the execute stage.
// Pure wiring, no latency of its own.
// No backpressure: the pipeline has no stall path through this stage.
interface execute_cycle_if #(
    parameter int XLEN = 32,
    parameter int REGW = 5
);
    // Control from decode
    logic            RegWriteE;
    logic            ALUSrcE;
    logic            MemWriteE;
    logic            ResultSrcE;
    logic            BranchE;
    logic [2:0]      ALUControlE;
    // Operands and bookkeeping from decode
    logic [XLEN-1:0] RD1_E;
    logic [XLEN-1:0] RD2_E;
    logic [XLEN-1:0] Imm_Ext_E;
    logic [REGW-1:0] RD_E;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] PCPlus4E;
    // Forwarding
    logic [XLEN-1:0] ResultW;
    logic [1:0]      ForwardAE;
    logic [1:0]      ForwardBE;
    // Branch outputs to fetch
    logic            PCSrcE;
    logic [XLEN-1:0] PCTargetE;
    // EX/MEM outputs
    logic            RegWriteM;
    logic            MemWriteM;
    logic            ResultSrcM;
    logic [REGW-1:0] RD_M;
    logic [XLEN-1:0] ALUResultM;
    logic [XLEN-1:0] WriteDataM;
    logic [XLEN-1:0] PCPlus4M;

    // Upstream side: drives the E-stage inputs, observes results
    modport master (
        output RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
               RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E,
               ResultW, ForwardAE, ForwardBE,
        input  PCSrcE, PCTargetE,
               RegWriteM, MemWriteM, ResultSrcM, RD_M, ALUResultM, WriteDataM, PCPlus4M
    );

    // Execute stage side
    modport slave (
        input  RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
               RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E,
               ResultW, ForwardAE, ForwardBE,
        output PCSrcE, PCTargetE,
               RegWriteM, MemWriteM, ResultSrcM, RD_M, ALUResultM, WriteDataM, PCPlus4M
    );
endinterface

// File: rtl/execute_cycle.sv
// RV32I execute stage: forwarding muxes, ALU, beq decision/target, EX/MEM register.
// Latency: branch outputs combinational (0 cycles); M outputs 1 cycle after E inputs.
// No backpressure: captures every cycle; bubbles arrive as all-zero control.
module execute_cycle #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic         clk,
    input  logic         rst,
    execute_cycle_if.slave ex
);

    typedef struct packed {
        logic            reg_write;
        logic            mem_write;
        logic            result_src;
        logic [REGW-1:0] rd;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] write_data;
        logic [XLEN-1:0] pc_plus4;
    } exmem_t;

    exmem_t          exmem_d;
    exmem_t          exmem_q;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic            zero;

    // Operand selection; code 11 falls back to the register file value.
    // ALUResultM is the registered result, so forwarding from it is loop-free.
    always_comb begin
        case (ex.ForwardAE)
            2'b01:   src_a = ex.ResultW;
            2'b10:   src_a = exmem_q.alu_result;
            default: src_a = ex.RD1_E;
        endcase
        case (ex.ForwardBE)
            2'b01:   fwd_b = ex.ResultW;
            2'b10:   fwd_b = exmem_q.alu_result;
            default: fwd_b = ex.RD2_E;
        endcase
        src_b = ex.ALUSrcE ? ex.Imm_Ext_E : fwd_b;
    end

    // ALU: wrap-around arithmetic, signed slt, unused codes give 0.
    always_comb begin
        case (ex.ALUControlE)
            3'b000:  alu_result = src_a + src_b;
            3'b001:  alu_result = src_a + ~src_b + {{(XLEN-1){1'b0}}, 1'b1};
            3'b010:  alu_result = src_a & src_b;
            3'b011:  alu_result = src_a | src_b;
            3'b101:  alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            default: alu_result = '0;
        endcase
        zero = (alu_result == '0);
    end

    assign ex.PCSrcE    = ex.BranchE & zero;
    assign ex.PCTargetE = ex.PCE + ex.Imm_Ext_E;

    // Next EX/MEM state; store data is the forwarded rs2, never the immediate.
    always_comb begin
        exmem_d            = '0;
        exmem_d.reg_write  = ex.RegWriteE;
        exmem_d.mem_write  = ex.MemWriteE;
        exmem_d.result_src = ex.ResultSrcE;
        exmem_d.rd         = ex.RD_E;
        exmem_d.alu_result = alu_result;
        exmem_d.write_data = fwd_b;
        exmem_d.pc_plus4   = ex.PCPlus4E;
    end

    // EX/MEM pipeline register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) exmem_q <= '0;
        else      exmem_q <= exmem_d;
    end

    assign ex.RegWriteM  = exmem_q.reg_write;
    assign ex.MemWriteM  = exmem_q.mem_write;
    assign ex.ResultSrcM = exmem_q.result_src;
    assign ex.RD_M       = exmem_q.rd;
    assign ex.ALUResultM = exmem_q.alu_result;
    assign ex.WriteDataM = exmem_q.write_data;
    assign ex.PCPlus4M   = exmem_q.pc_plus4;

endmodule

// File: doc/execute_cycle.md
Name: execute_cycle

Overview:
Execute stage of the 5-stage RV32I pipeline. It sits between decode and memory.
- Consumes the ID/EX register outputs (control, operands, immediate, PC, destination register) plus forwarding selects from the hazard unit.
- Computes the ALU result, branch decision and branch target.
- Registers the EX/MEM pipeline state for the memory stage.

Parameters:
XLEN, 32, datapath width in bits.
REGW, 5, register-index width.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-low reset.
RegWriteE  input  1  register-write enable from decode.
ALUSrcE  input  1  ALU operand B select: 0 = forwarded rs2, 1 = immediate.
MemWriteE  input  1  store enable.
ResultSrcE  input  1  writeback select: 0 = ALU, 1 = memory.
BranchE  input  1  beq instruction flag.
ALUControlE  input  3  ALU operation.
RD1_E  input  XLEN  rs1 value from the register file.
RD2_E  input  XLEN  rs2 value from the register file.
Imm_Ext_E  input  XLEN  sign-extended immediate.
RD_E  input  REGW  destination register index.
PCE  input  XLEN  PC of the instruction.
PCPlus4E  input  XLEN  PC+4.
ResultW  input  XLEN  writeback-stage result, forwarding source.
ForwardAE  input  2  operand A source select.
ForwardBE  input  2  operand B source select.
PCSrcE  output  1  branch taken; combinational, to fetch.
PCTargetE  output  XLEN  PCE + Imm_Ext_E; combinational.
RegWriteM  output  1  registered RegWriteE.
MemWriteM  output  1  registered MemWriteE.
ResultSrcM  output  1  registered ResultSrcE.
RD_M  output  REGW  registered RD_E.
ALUResultM  output  XLEN  registered ALU result.
WriteDataM  output  XLEN  registered forwarded rs2, i.e. store data.
PCPlus4M  output  XLEN  registered PCPlus4E.

Behaviour:
Reset:
- rst low forces every registered output (RegWriteM through PCPlus4M) to 0 immediately, independent of clk.
- While rst is held low, registers hold 0.
- First capture occurs on the first rising clk edge after rst deasserts.

Forwarding muxes (combinational):
- SrcA = RD1_E when ForwardAE=00; ResultW when 01; ALUResultM when 10.
- 11 behaves as 00.
- FwdB uses the same rule with RD2_E and ForwardBE.

Operand B:
- SrcB = Imm_Ext_E if ALUSrcE=1, else FwdB.

ALU (combinational, XLEN wide, wrap-around, no carry or overflow outputs):
- 000 = add.
- 001 = sub (SrcA + ~SrcB + 1).
- 010 = and.
- 011 = or.
- 101 = slt, signed: result is 1 if SrcA < SrcB as two's complement, else 0; zero-extended to XLEN.
- Any other code yields 0.
- ZeroE = (ALU result == 0).

Branch:
- PCSrcE = BranchE & ZeroE.
- PCTargetE = PCE + Imm_Ext_E, modulo 2^XLEN.
- Both are combinational, zero latency. Fetch consumes them in the same cycle.

EX/MEM register, on each rising clk with rst high, captures:
- RegWriteE, MemWriteE, ResultSrcE, RD_E, PCPlus4E;
- the ALU result into ALUResultM;
- FwdB into WriteDataM. Store data is always forwarded rs2, never the immediate.

Latency and control:
- Latency is 1 cycle from E inputs to M outputs.
- No stall or flush inputs. Bubbles arrive as all-zero control from upstream and propagate unchanged.
- ALUResultM feeds back into the forwarding mux. The value selected by ForwardAE=10 is the previous cycle's result; there is no combinational loop.
- PCSrcE is not registered and has no effect on the EX/MEM capture.

Test Plan:
- Reset: rst=0 mid-simulation with nonzero M outputs -> all M outputs read 0 before the next clk edge; they stay 0 until a clk edge after rst=1.
- Add-immediate: RD1_E=5, Imm_Ext_E=7, ALUSrcE=1, ALUControlE=000, RD_E=3, RegWriteE=1 -> after 1 edge: ALUResultM=12, RD_M=3, RegWriteM=1.
- Forwarding, back-to-back:
  - Cycle 1: sub with 10-4 -> ALUResultM=6.
  - Cycle 2: ForwardAE=10, RD1_E=99 (stale), Imm=1, add -> ALUResultM=7.
  - Cycle 3: ForwardAE=01, ResultW=0x100, add of 0x100+1 -> 0x101.
- Branch taken: BranchE=1, ALUControlE=001, RD1_E=RD2_E=0x20, PCE=0x40, Imm=0xFFFFFFF8 -> PCSrcE=1, PCTargetE=0x38 in the same cycle. With RD2_E=0x21 -> PCSrcE=0.
- slt signed: SrcA=0xFFFFFFFF, SrcB=1 -> result 1. Swapped operands -> 0. Also check 0x7FFFFFFF+1 under add wraps to 0x80000000.
- Store: MemWriteE=1, ALUSrcE=1, Imm=8, RD1_E=0x1000, ForwardBE=01, ResultW=0xDEADBEEF -> ALUResultM=0x1008, WriteDataM=0xDEADBEEF, MemWriteM=1.
